// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings and the
// instruction value presented when no valid instruction is available.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_KILL = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit.sv
// Single-issue instruction fetch with stall hold and one-bubble redirect.
// Define FETCH_MISALIGN_TRAP_EN to vector misaligned redirects to EXC_VECTOR.
//
// state | meaning
// BOOT  | first address presented after reset, no instruction returned yet
// RUN   | imem_inst holds the word at f_pc_q, one instruction per cycle
// KILL  | returned word belongs to the path abandoned by a redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          INST_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
    input  logic                          clk,
    input  logic                          resetpc,
    input  logic                          stall,
    input  logic                          redirect_valid,
    input  logic [31:0]                   redirect_target,
    output logic [$clog2(INST_DEPTH)-1:0] imem_addr,
    input  logic [31:0]                   imem_inst,
    output logic [31:0]                   inst_out,
    output logic [31:0]                   pc_out,
    output logic [31:0]                   pc_plus4,
    output logic                          inst_valid,
    output logic                          misalign_err
);

    localparam int AW = $clog2(INST_DEPTH);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  f_pc_q, f_pc_d;
    logic         misalign_q, misalign_d;
    logic [31:0]  target_eff;
    logic         target_bad;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign target_bad = (redirect_target[1:0] != 2'b00);
    assign target_eff = target_bad ? EXC_VECTOR : redirect_target;
`else
    assign target_bad = 1'b0;
    assign target_eff = redirect_target & ~32'h0000_0003;
`endif

    always_ff @(posedge clk) begin
        if (resetpc) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            f_pc_q     <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f_pc_q     <= f_pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f_pc_d     = f_pc_q;
        misalign_d = 1'b0;
        if (redirect_valid) begin
            // A redirect wins over stall and over a redirect already in flight.
            state_d    = ST_KILL;
            pc_d       = target_eff;
            f_pc_d     = pc_q;
            misalign_d = target_bad;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        pc_d   = pc_q + PC_STEP;
                        f_pc_d = pc_q;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    pc_d    = pc_q + PC_STEP;
                    f_pc_d  = pc_q;
                end
            endcase
        end
    end

    // While stalled, re-present the held address so imem_inst stays unchanged.
    assign imem_addr    = (state_q == ST_RUN && stall) ? f_pc_q[AW+1:2] : pc_q[AW+1:2];
    assign inst_valid   = (state_q == ST_RUN);
    assign inst_out     = inst_valid ? imem_inst : NOP;
    assign pc_out       = f_pc_q;
    assign pc_plus4     = f_pc_q + PC_STEP;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a registered instruction memory.
module tb_fetch_unit;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetpc, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [7:0]  imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] inst_out, pc_out, pc_plus4;
    logic        inst_valid, misalign_err;

    logic [31:0] mem [256];
    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] tgt;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic        emis;
        logic        ca;
        logic [7:0]  eaddr;
    } vec_t;

    vec_t vt[$];

    fetch_unit dut (
        .clk             (clk),
        .resetpc         (resetpc),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_inst       (imem_inst),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .inst_valid      (inst_valid),
        .misalign_err    (misalign_err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (resetpc) imem_inst <= 32'h0;
        else         imem_inst <= mem[imem_addr];
    end

    function automatic logic [31:0] m(input int w);
        return 32'hC0DE_0000 | 32'(w);
    endfunction

    function automatic vec_t v(input logic rst, input logic st, input logic rv,
                               input logic [31:0] tgt, input logic ev,
                               input logic [31:0] epc, input logic [31:0] einst,
                               input logic emis, input logic ca, input logic [7:0] ea);
        vec_t r;
        r.rst = rst; r.stall = st; r.rv = rv; r.tgt = tgt; r.ev = ev;
        r.epc = epc; r.einst = einst; r.emis = emis; r.ca = ca; r.eaddr = ea;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t x);
        resetpc         = x.rst;
        stall           = x.stall;
        redirect_valid  = x.rv;
        redirect_target = x.tgt;
        #1;
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, x.ev});
        if (x.ev) begin
            chk("pc_out", pc_out, x.epc);
            chk("inst_out", inst_out, x.einst);
            chk("pc_plus4", pc_plus4, x.epc + 32'd4);
        end else begin
            chk("inst_out_nop", inst_out, 32'h0);
        end
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, x.emis});
        if (x.ca) chk("imem_addr", {24'b0, imem_addr}, {24'b0, x.eaddr});
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = m(i);
        resetpc = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

        //        rst st rv tgt           ev pc                      inst                    mis   ca addr
        vt.push_back(v(1, 0, 0, 32'h0,     0, 0,                     0,                      0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    1, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h0,                 m(0),                   0,    1, 1));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h4,                 m(1),                   0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h40,    1, 32'h8,                 m(2),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    1, 16));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h40,                m(16),                  0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h8,     1, 32'h44,                m(17),                  0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    0, 0));
        vt.push_back(v(0, 1, 0, 32'h0,     1, 32'h8,                 m(2),                   0,    1, 2));
        vt.push_back(v(0, 1, 0, 32'h0,     1, 32'h8,                 m(2),                   0,    0, 0));
        vt.push_back(v(0, 1, 0, 32'h0,     1, 32'h8,                 m(2),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h8,                 m(2),                   0,    1, 3));
        vt.push_back(v(0, 1, 1, 32'h20,    1, 32'hC,                 m(3),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    1, 8));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h20,                m(8),                   0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h42,    1, 32'h24,                m(9),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      TRAP, 0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     1, TRAP ? 32'h180 : 32'h40, TRAP ? m(96) : m(16), 0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h100,   1, TRAP ? 32'h184 : 32'h44, TRAP ? m(97) : m(17), 0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h200,   0, 0,                     0,                      0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    1, 128));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h200,               m(128),                 0,    0, 0));
        vt.push_back(v(0, 0, 1, 32'h3FC,   1, 32'h204,               m(129),                 0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    1, 255));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h3FC,               m(255),                 0,    1, 0));
        vt.push_back(v(0, 0, 1, 32'h3FC,   1, 32'h400,               m(0),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     0, 0,                     0,                      0,    0, 0));
        vt.push_back(v(0, 1, 0, 32'h0,     1, 32'h3FC,               m(255),                 0,    1, 255));
        vt.push_back(v(1, 1, 0, 32'h0,     1, 32'h3FC,               m(255),                 0,    0, 0));
        vt.push_back(v(1, 1, 0, 32'h0,     0, 0,                     0,                      0,    0, 0));
        vt.push_back(v(0, 1, 0, 32'h0,     0, 0,                     0,                      0,    1, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h0,                 m(0),                   0,    0, 0));
        vt.push_back(v(0, 0, 0, 32'h0,     1, 32'h4,                 m(1),                   0,    0, 0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vt.size(); i++) run_vec(vt[i]);

        // Reset mid-run, then a redirect taken in the BOOT cycle to the top of
        // the address space: pc_plus4 wraps to 0 and imem_addr wraps as well.
        run_vec(v(1, 0, 0, 32'h0,         1, 32'h8,         m(2),   0, 0, 0));
        run_vec(v(0, 1, 1, 32'hFFFF_FFFC, 0, 0,             0,      0, 0, 0));
        run_vec(v(0, 0, 0, 32'h0,         0, 0,             0,      0, 1, 255));
        run_vec(v(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, m(255), 0, 1, 0));
        run_vec(v(0, 0, 0, 32'h0,         1, 32'h0,         m(0),   0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter INST_DEPTH, default 256, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address fetched first after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0180, byte address taken on a misaligned redirect.
REQ-004 SHALL have port clk  input  1  sole clock, all state on posedge.
REQ-005 SHALL have port resetpc  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port stall  input  1  downstream cannot accept this cycle's instruction.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump taken this cycle.
REQ-008 SHALL have port redirect_target  input  32  byte target of redirect.
REQ-009 SHALL have port imem_addr  output  $clog2(INST_DEPTH)  word address to instruction memory.
REQ-010 SHALL have port imem_inst  input  32  instruction memory data, registered, 1-cycle latency, 0 while memory is in reset.
REQ-011 SHALL have port inst_out  output  32  fetched instruction.
REQ-012 SHALL have port pc_out  output  32  byte PC of inst_out.
REQ-013 SHALL have port pc_plus4  output  32  pc_out + 4, modulo 2^32.
REQ-014 SHALL have port inst_valid  output  1  inst_out/pc_out are meaningful.
REQ-015 SHALL have port misalign_err  output  1  one-cycle pulse on misaligned redirect.

Function
REQ-016 SHALL hold registers pc_q (address being presented), f_pc_q (address presented last cycle) and a 3-state FSM: BOOT, RUN, KILL.
REQ-017 SHALL drive imem_addr = f_pc_q[$clog2(INST_DEPTH)+1:2] when state==RUN and stall==1, else pc_q[$clog2(INST_DEPTH)+1:2]; upper bits alias (wrap).
REQ-018 SHALL drive inst_valid = (state==RUN), inst_out = inst_valid ? imem_inst : 32'h0000_0000, pc_out = f_pc_q.
REQ-019 SHALL, in RUN with stall=0 and no redirect, on posedge: f_pc_q<=pc_q, pc_q<=pc_q+4 (wraps), stay RUN; one instruction per cycle.
REQ-020 SHALL, in RUN with stall=1 and no redirect, hold pc_q, f_pc_q and state so inst_out/pc_out remain identical next cycle.
REQ-021 SHALL, in BOOT, ignore stall: f_pc_q<=pc_q, pc_q<=pc_q+4, go to RUN.
REQ-022 SHALL, in KILL, ignore stall: f_pc_q<=pc_q, pc_q<=pc_q+4, go to RUN; the in-flight instruction is discarded (inst_valid=0).
REQ-023 SHALL, on redirect_valid=1 in any state, override stall: pc_q<=redirect_target, f_pc_q<=pc_q, state<=KILL; penalty is exactly one bubble.
REQ-024 SHALL treat a redirect while in KILL as a new redirect (remains KILL, new target wins).

Reset
REQ-025 SHALL, when resetpc=1 at posedge, set pc_q<=RESET_PC, f_pc_q<=RESET_PC, state<=BOOT, misalign_err<=0, regardless of stall/redirect, including mid-stall or mid-KILL.
REQ-026 SHALL give first inst_valid=1 (pc_out=RESET_PC) on the second cycle after resetpc deasserts.

Configuration
REQ-027 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on redirect with redirect_target[1:0]!=0 load pc_q<=EXC_VECTOR and pulse misalign_err=1 for the following cycle; otherwise as REQ-023.
REQ-028 SHALL, without FETCH_MISALIGN_TRAP_EN, force redirect_target[1:0] to 00 and tie misalign_err to 0.

Structure
REQ-029 SHALL take FSM state encodings and the NOP constant from shared package fetch_pkg.
REQ-030 SHALL be a single module with no sub-module; the instruction memory is instantiated outside by the parent.

Verification
REQ-031 SHALL test reset release, no stall: cycles 1..4 after release -> inst_valid 0,1,1,1; pc_out x,0x0,0x4,0x8; inst_out = mem[0],mem[1],mem[2].
REQ-032 SHALL test stall for 3 cycles while pc_out=0x8 -> pc_out/inst_out frozen at 0x8/mem[2] for 3 cycles, then 0xC next.
REQ-033 SHALL test redirect to 0x40 while pc_out=0x8 -> next cycle inst_valid=0, following cycle pc_out=0x40, inst_out=mem[16].
REQ-034 SHALL test simultaneous stall=1 and redirect to 0x20 -> redirect taken, one bubble, then pc_out=0x20.
REQ-035 SHALL test redirect to 0x42 -> with FETCH_MISALIGN_TRAP_EN misalign_err pulse, then pc_out=0x180; without it, pc_out=0x40, misalign_err=0.
REQ-036 SHALL test resetpc asserted during a stall at pc_out=0x3FC -> outputs invalid, restart at 0x0; also 0x3FC->0x400 wraps imem_addr to 0.
